// File: rtl/mcu_spi.sv
// SPI mode-0 target bridging the MCU byte protocol to the system control byte stream.
// Pins are synchronized into clk; replies are loaded two clocks after each received byte.
module mcu_spi #(
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_io_ss,
    input  logic       spi_io_clk,
    input  logic       spi_io_din,
    output logic       spi_io_dout,
    output logic       data_out_strobe,
    output logic       data_out_start,
    output logic [7:0] data_out,
    input  logic [7:0] data_in
);

    // Stage [1] is the synchronized level, stage [2] the history for edge detection.
    logic [2:0] ss_pipe;
    logic [2:0] sck_pipe;
    logic [1:0] din_pipe;

    logic [6:0] rx_sr;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic       first;
    logic [1:0] load_pipe;

    logic selected;
    logic ss_fall;
    logic sck_rise;
    logic sck_fall;
    logic mosi_sync;
    logic byte_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_pipe  <= 3'b111;
            sck_pipe <= 3'b000;
            din_pipe <= 2'b00;
        end else begin
            ss_pipe  <= {ss_pipe[1:0], spi_io_ss};
            sck_pipe <= {sck_pipe[1:0], spi_io_clk};
            din_pipe <= {din_pipe[0], spi_io_din};
        end
    end

    always_comb begin
        selected  = ~ss_pipe[1];
        ss_fall   = ~ss_pipe[1] & ss_pipe[2];
        sck_rise  = sck_pipe[1] & ~sck_pipe[2];
        sck_fall  = ~sck_pipe[1] & sck_pipe[2];
        mosi_sync = din_pipe[1];
        byte_done = selected & ~ss_fall & sck_rise & (bit_cnt == 3'd7);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sr           <= 7'h00;
            bit_cnt         <= 3'd0;
            tx_sr           <= IDLE_BYTE;
            first           <= 1'b0;
            load_pipe       <= 2'b00;
            data_out        <= 8'h00;
            data_out_strobe <= 1'b0;
            data_out_start  <= 1'b0;
        end else begin
            data_out_strobe <= 1'b0;
            if (ss_fall) begin
                // Selection start wins over any coincident SCK edge.
                bit_cnt   <= 3'd0;
                first     <= 1'b1;
                tx_sr     <= IDLE_BYTE;
                load_pipe <= 2'b00;
            end else if (!selected) begin
                // Deselection drops a partial byte and any reply load in flight.
                bit_cnt   <= 3'd0;
                load_pipe <= 2'b00;
            end else begin
                load_pipe <= {load_pipe[0], byte_done};
                if (sck_rise) begin
                    rx_sr   <= {rx_sr[5:0], mosi_sync};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    data_out        <= {rx_sr, mosi_sync};
                    data_out_strobe <= 1'b1;
                    data_out_start  <= first;
                    first           <= 1'b0;
                end
                if (load_pipe[1]) begin
                    tx_sr <= data_in;
                end else if (sck_fall && bit_cnt != 3'd0) begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
            end
        end
    end

    assign spi_io_dout = selected & tx_sr[7];

endmodule

// File: tb/tb_mcu_spi.sv
// Scoreboard bench for mcu_spi: an SPI master drives bytes, monitors check received
// strobes against expected bytes and MISO bytes against the modelled reply stream.
module tb_mcu_spi;

    localparam logic [7:0] IDLE = 8'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_io_ss = 1'b1;
    logic       spi_io_clk = 1'b0;
    logic       spi_io_din = 1'b0;
    logic       spi_io_dout;
    logic       data_out_strobe;
    logic       data_out_start;
    logic [7:0] data_out;
    logic [7:0] data_in = 8'h00;

    mcu_spi #(
        .IDLE_BYTE(IDLE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .spi_io_ss      (spi_io_ss),
        .spi_io_clk     (spi_io_clk),
        .spi_io_din     (spi_io_din),
        .spi_io_dout    (spi_io_dout),
        .data_out_strobe(data_out_strobe),
        .data_out_start (data_out_start),
        .data_out       (data_out),
        .data_in        (data_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] rx_q[$];    // {start, byte} expected per strobe
    logic [7:0] reply_q[$]; // system control reply per received byte
    logic [7:0] miso_q[$];  // expected MISO byte per completed SPI byte

    logic [7:0] tx_buf[16];
    logic [7:0] rp_buf[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Receive monitor plus system control model supplying the next reply.
    always @(negedge clk) begin
        if (!reset && data_out_strobe) begin
            if (rx_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got data %0h start %0b expected none",
                         data_out, data_out_start);
            end else begin
                logic [8:0] e;
                e = rx_q.pop_front();
                chk("rx_data", data_out, e[7:0]);
                chk("rx_start", data_out_start, e[8]);
            end
            data_in = (reply_q.size() != 0) ? reply_q.pop_front() : 8'($urandom);
        end
    end

    // MISO monitor samples on SCK rise like the MCU does.
    logic [7:0] miso_sr = 8'h00;
    int         miso_cnt = 0;
    always @(posedge spi_io_clk) begin
        if (!spi_io_ss && !reset) begin
            miso_sr = {miso_sr[6:0], spi_io_dout};
            miso_cnt++;
            if (miso_cnt == 8) begin
                miso_cnt = 0;
                if (miso_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_miso_byte: got %0h expected none", miso_sr);
                end else begin
                    chk("miso_byte", miso_sr, miso_q.pop_front());
                end
            end
        end
    end
    always @(posedge spi_io_ss or posedge reset) miso_cnt = 0;

    task automatic spi_bits(input logic [7:0] b, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            spi_io_din = b[7-i];
            wait_clk(half);
            spi_io_clk = 1'b1;
            wait_clk(half);
            spi_io_clk = 1'b0;
        end
    endtask

    // Full transaction of n bytes from tx_buf; rp_buf holds the replies to each byte.
    task automatic spi_xfer(input int n, input int half, input int gap);
        for (int k = 0; k < n; k++) begin
            rx_q.push_back({(k == 0), tx_buf[k]});
            reply_q.push_back(rp_buf[k]);
            miso_q.push_back((k == 0) ? IDLE : rp_buf[k-1]);
        end
        spi_io_ss = 1'b0;
        wait_clk(4);
        for (int k = 0; k < n; k++) begin
            spi_bits(tx_buf[k], 8, half);
            if (gap > 0) wait_clk(gap);
        end
        wait_clk(4);
        spi_io_ss = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        wait_clk(3);
        chk("reset_dout", spi_io_dout, 1'b0);
        chk("reset_strobe", data_out_strobe, 1'b0);
        chk("reset_start", data_out_start, 1'b0);
        chk("reset_data", data_out, 8'h00);
        reset = 1'b0;
        wait_clk(4);

        // Single byte.
        tx_buf[0] = 8'hA5; rp_buf[0] = 8'h11;
        spi_xfer(1, 4, 0);

        // Three zero bytes with fixed replies.
        tx_buf[0] = 8'h00; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        rp_buf[0] = 8'h5C; rp_buf[1] = 8'h42; rp_buf[2] = 8'h99;
        spi_xfer(3, 4, 0);

        // Abort after 5 bits, then a fresh transaction.
        spi_io_ss = 1'b0;
        wait_clk(4);
        spi_bits(8'hFF, 5, 4);
        wait_clk(4);
        spi_io_ss = 1'b1;
        wait_clk(6);
        tx_buf[0] = 8'h3C; rp_buf[0] = 8'h00;
        spi_xfer(1, 4, 0);

        // 16 bytes at clk/8 with the minimum byte gap.
        for (int k = 0; k < 16; k++) begin
            tx_buf[k] = 8'(k);
            rp_buf[k] = 8'($urandom);
        end
        spi_xfer(16, 4, 0);

        // Reset pulsed asynchronously during bit 4.
        spi_io_ss = 1'b0;
        wait_clk(4);
        spi_bits(8'h81, 3, 4);
        spi_io_din = 1'b0;
        wait_clk(4);
        spi_io_clk = 1'b1;
        #3 reset = 1'b1;
        #1;
        chk("midreset_dout", spi_io_dout, 1'b0);
        chk("midreset_strobe", data_out_strobe, 1'b0);
        chk("midreset_start", data_out_start, 1'b0);
        chk("midreset_data", data_out, 8'h00);
        wait_clk(3);
        spi_io_clk = 1'b0;
        #3 reset = 1'b0;
        wait_clk(2);
        spi_bits(8'h00, 4, 4);
        wait_clk(4);
        spi_io_ss = 1'b1;
        wait_clk(6);
        tx_buf[0] = 8'h81; rp_buf[0] = 8'h00;
        spi_xfer(1, 4, 0);

        // SCK toggled while deselected.
        for (int i = 0; i < 8; i++) begin
            spi_io_din = 1'($urandom);
            wait_clk(4);
            spi_io_clk = 1'b1;
            wait_clk(4);
            chk("deselected_dout", spi_io_dout, 1'b0);
            spi_io_clk = 1'b0;
        end
        wait_clk(6);

        // Randomized transactions with varying SCK rate and byte gaps.
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                tx_buf[k] = 8'($urandom);
                rp_buf[k] = 8'($urandom);
            end
            spi_xfer(n, $urandom_range(4, 6), $urandom_range(0, 3));
        end

        wait_clk(20);
        chk("pending_rx", rx_q.size(), 0);
        chk("pending_miso", miso_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
